// File: rtl/seq_mul_div_if.sv
// Request/response bundle for the multi-cycle multiply/divide engine.
// The requester drives start/op/a/b; the engine returns busy/done and
// the hi/lo result pair plus the sticky divide-by-zero flag.
interface seq_mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/seq_mul_div.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes) engine. Results land on hi/lo: the 2*WIDTH-bit product, or
// remainder/quotient. Divide by zero finishes one cycle after the start edge.
// Optional: define MULDIV_ZERO_SKIP_EN to finish trivially-zero operations
// (multiply by zero, zero dividend) without the iterative phase.
module seq_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // First RUN cycle loads the accumulator from the latched operands.
    logic              prep_q, prep_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    // Upper accumulator carries one guard bit so that subtracting the
    // most-negative multiplicand cannot overflow before the shift.
    logic [WIDTH:0]    acc_a_q, acc_a_d;
    logic [WIDTH-1:0]  acc_q_q, acc_q_d;
    logic              qm1_q, qm1_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    m_ext, booth_sum;
    logic [WIDTH:0]    booth_a;
    logic [WIDTH-1:0]  booth_q;
    logic              booth_qm1;
    logic [WIDTH:0]    div_rs;
    logic [WIDTH+1:0]  div_diff;
    logic [WIDTH:0]    div_a;
    logic [WIDTH-1:0]  div_q;
    logic [WIDTH-1:0]  q_fix, r_fix;

    // Operand magnitudes for the divider (most-negative maps to 2^(W-1)).
    always_comb begin : magnitudes
        a_mag = a_q[WIDTH-1] ? (~a_q + 1'b1) : a_q;
        b_mag = b_q[WIDTH-1] ? (~b_q + 1'b1) : b_q;
    end

    // One Booth step: add/subtract multiplicand, then arithmetic right shift.
    always_comb begin : booth_step
        m_ext = {a_q[WIDTH-1], a_q};
        case ({acc_q_q[0], qm1_q})
            2'b01:   booth_sum = acc_a_q + m_ext;
            2'b10:   booth_sum = acc_a_q - m_ext;
            default: booth_sum = acc_a_q;
        endcase
        {booth_a, booth_q, booth_qm1} = {booth_sum[WIDTH], booth_sum, acc_q_q};
    end

    // One restoring-division step on magnitudes, plus final sign fix-up.
    always_comb begin : div_step
        div_rs   = {acc_a_q[WIDTH-1:0], acc_q_q[WIDTH-1]};
        div_diff = {1'b0, div_rs} - {2'b00, b_mag};
        if (!div_diff[WIDTH+1]) begin
            div_a = div_diff[WIDTH:0];
            div_q = {acc_q_q[WIDTH-2:0], 1'b1};
        end else begin
            div_a = div_rs;
            div_q = {acc_q_q[WIDTH-2:0], 1'b0};
        end
        // Quotient truncates toward zero; remainder follows the dividend.
        q_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? (~div_q + 1'b1) : div_q;
        r_fix = a_q[WIDTH-1] ? (~div_a[WIDTH-1:0] + 1'b1) : div_a[WIDTH-1:0];
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
    always_comb begin : fsm_next
        state_d = state_q;
        cnt_d   = cnt_q;
        prep_d  = prep_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_a_d = acc_a_q;
        acc_q_d = acc_q_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    a_d    = bus.a;
                    b_d    = bus.b;
                    dbz_d  = 1'b0;
                    cnt_d  = '0;
                    prep_d = 1'b1;
                    if (bus.op && (bus.b == '0)) begin
                        state_d = S_DONE;
                        lo_d    = '1;
                        hi_d    = bus.a;
                        dbz_d   = 1'b1;
                    end
`ifdef MULDIV_ZERO_SKIP_EN
                    else if ((!bus.op && ((bus.a == '0) || (bus.b == '0))) ||
                             (bus.op && (bus.a == '0))) begin
                        state_d = S_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                    end
`endif
                    else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (prep_q) begin
                    prep_d  = 1'b0;
                    acc_a_d = '0;
                    qm1_d   = 1'b0;
                    acc_q_d = op_q ? a_mag : b_q;
                end else begin
                    acc_a_d = op_q ? div_a : booth_a;
                    acc_q_d = op_q ? div_q : booth_q;
                    qm1_d   = op_q ? 1'b0 : booth_qm1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        if (op_q) begin
                            lo_d = q_fix;
                            hi_d = r_fix;
                        end else begin
                            hi_d = booth_a[WIDTH-1:0];
                            lo_d = booth_q;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers; reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin : data_reg
        if (!rst_n) begin
            cnt_q   <= '0;
            prep_q  <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_a_q <= '0;
            acc_q_q <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            prep_q  <= prep_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_a_q <= acc_a_d;
            acc_q_q <= acc_q_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_mul_div.sv
// Directed self-checking bench for seq_mul_div (WIDTH = 32).
module tb_seq_mul_div;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    int   lat;
    int   npulse;
    logic busy0;
    int   k;

    seq_mul_div_if #(.WIDTH(W)) bus ();

    seq_mul_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one operation, optionally poke start at window index 'poke',
    // and watch 40 cycles for done. Latency index 0 = cycle after start edge.
    task automatic run(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int poke, output int l, output int np, output logic b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~o;
        bus.a     = $urandom;
        bus.b     = $urandom;
        b0 = bus.busy;
        l  = -1;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                np++;
                if (l < 0) l = i;
            end
            if (i == poke) begin
                bus.start = 1'b1;
                bus.op    = 1'b0;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_hi",   bus.hi, 0);
        check("reset_lo",   bus.lo, 0);
        check("reset_dbz",  bus.div_by_zero, 0);

        run(1'b0, 32'd7, 32'hFFFFFFFD, -1, lat, npulse, busy0);
        $display("mul 7 x -3: lat=%0d hi=%h lo=%h", lat, bus.hi, bus.lo);
        check("mul_busy_from_start", busy0, 1);
        check("mul_latency", lat, 33);
        check("mul_pulses", npulse, 1);
        check("mul_7x-3_hi", bus.hi, 32'hFFFFFFFF);
        check("mul_7x-3_lo", bus.lo, 32'hFFFFFFEB);

        run(1'b0, 32'h80000000, 32'h80000000, -1, lat, npulse, busy0);
        $display("mul min x min: hi=%h lo=%h", bus.hi, bus.lo);
        check("mul_minmin_hi", bus.hi, 32'h40000000);
        check("mul_minmin_lo", bus.lo, 32'h00000000);

        run(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, lat, npulse, busy0);
        $display("mul max x max: hi=%h lo=%h", bus.hi, bus.lo);
        check("mul_maxmax_hi", bus.hi, 32'h3FFFFFFF);
        check("mul_maxmax_lo", bus.lo, 32'h00000001);

        run(1'b0, 32'd0, 32'd5, -1, lat, npulse, busy0);
        $display("mul 0 x 5: hi=%h lo=%h", bus.hi, bus.lo);
        check("mul_zero_hi", bus.hi, 32'h0);
        check("mul_zero_lo", bus.lo, 32'h0);

        run(1'b1, 32'hFFFFFFF9, 32'd2, -1, lat, npulse, busy0);
        $display("div -7 / 2: lat=%0d hi=%h lo=%h dbz=%b", lat, bus.hi, bus.lo, bus.div_by_zero);
        check("div_latency", lat, 33);
        check("div_-7/2_lo", bus.lo, 32'hFFFFFFFD);
        check("div_-7/2_hi", bus.hi, 32'hFFFFFFFF);
        check("div_-7/2_dbz", bus.div_by_zero, 0);

        run(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, lat, npulse, busy0);
        $display("div min / -1: hi=%h lo=%h dbz=%b", bus.hi, bus.lo, bus.div_by_zero);
        check("div_min/-1_lo", bus.lo, 32'h80000000);
        check("div_min/-1_hi", bus.hi, 32'h0);
        check("div_min/-1_dbz", bus.div_by_zero, 0);

        run(1'b1, 32'd100, 32'hFFFFFFF9, -1, lat, npulse, busy0);
        $display("div 100 / -7: hi=%h lo=%h", bus.hi, bus.lo);
        check("div_100/-7_lo", bus.lo, 32'hFFFFFFF2);
        check("div_100/-7_hi", bus.hi, 32'd2);

        run(1'b1, 32'hFFFFFF9C, 32'd7, -1, lat, npulse, busy0);
        $display("div -100 / 7: hi=%h lo=%h", bus.hi, bus.lo);
        check("div_-100/7_lo", bus.lo, 32'hFFFFFFF2);
        check("div_-100/7_hi", bus.hi, 32'hFFFFFFFE);

        run(1'b1, 32'd10, 32'd0, -1, lat, npulse, busy0);
        $display("div 10 / 0: lat=%0d hi=%h lo=%h dbz=%b", lat, bus.hi, bus.lo, bus.div_by_zero);
        check("dbz_latency", lat, 0);
        check("dbz_pulses", npulse, 1);
        check("dbz_flag", bus.div_by_zero, 1);
        check("dbz_lo", bus.lo, 32'hFFFFFFFF);
        check("dbz_hi", bus.hi, 32'h0000000A);

        run(1'b1, 32'd10, 32'd3, -1, lat, npulse, busy0);
        $display("div 10 / 3: hi=%h lo=%h dbz=%b", bus.hi, bus.lo, bus.div_by_zero);
        check("div_10/3_dbz_cleared", bus.div_by_zero, 0);
        check("div_10/3_lo", bus.lo, 32'd3);
        check("div_10/3_hi", bus.hi, 32'd1);

        run(1'b0, 32'd5, 32'd6, 10, lat, npulse, busy0);
        $display("mul 5 x 6 with stray start: lat=%0d pulses=%0d hi=%h lo=%h", lat, npulse, bus.hi, bus.lo);
        check("stray_latency", lat, 33);
        check("stray_pulses", npulse, 1);
        check("stray_hi", bus.hi, 32'd0);
        check("stray_lo", bus.lo, 32'd30);

        // Reset in the middle of 100 / 7.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-run: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) npulse++;
        end
        $display("after reset release: done pulses=%0d busy=%b", npulse, bus.busy);
        check("rst_no_done", npulse, 0);
        check("rst_idle", bus.busy, 0);

        run(1'b1, 32'd100, 32'd7, -1, lat, npulse, busy0);
        $display("div 100 / 7: lat=%0d hi=%h lo=%h", lat, bus.hi, bus.lo);
        check("div_100/7_latency", lat, 33);
        check("div_100/7_lo", bus.lo, 32'd14);
        check("div_100/7_hi", bus.hi, 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
